// File: rtl/archtable_recover_ctrl_pkg.sv
// rtl/archtable_recover_ctrl_pkg.sv - shared sizes, state encoding and lane slicing for arch-table recovery
package archtable_recover_ctrl_pkg;

    localparam int CDBWIDTH    = 6;
    localparam int NUM_AREGS   = 32;
    localparam int PREG_W      = CDBWIDTH;
    localparam int AREG_IDX_W  = $clog2(NUM_AREGS);
    localparam int EPC_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COPY = 1'b1
    } rec_state_t;

    // Extract arch entry idx from the flattened archtable copy bus.
    function automatic logic [PREG_W-1:0] at_lane(
        input logic [NUM_AREGS*PREG_W-1:0] flat,
        input int                          idx
    );
        return flat[idx*PREG_W +: PREG_W];
    endfunction

endpackage

// File: rtl/archtable_recover_ctrl_grp_mux.sv
// rtl/archtable_recover_ctrl_grp_mux.sv - combinational NGRP:1 select of one EPC-wide snapshot group
module archtable_grp_mux
    import archtable_recover_ctrl_pkg::*;
#(
    parameter int EPC   = EPC_DEFAULT,
    parameter int NGRP  = NUM_AREGS / EPC,
    parameter int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic [NUM_AREGS*PREG_W-1:0] snap_flat,
    input  logic [GRP_W-1:0]            grp_sel,
    output logic [EPC*PREG_W-1:0]       grp_data
);

    localparam int GW = EPC * PREG_W;

    // Pick the group whose index matches grp_sel; unmatched selects read 0.
    always_comb begin
        grp_data = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (grp_sel == GRP_W'(g)) begin
                grp_data = snap_flat[g*GW +: GW];
            end
        end
    end

endmodule

// File: rtl/archtable_recover_ctrl.sv
// rtl/archtable_recover_ctrl.sv - snapshot the arch table on flush and stream it into the map table
module archtable_recover_ctrl
    import archtable_recover_ctrl_pkg::*;
#(
    parameter int EPC = EPC_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rob_recover,
    input  logic                          retire_en_any,
    input  logic [NUM_AREGS*PREG_W-1:0]   at_copy,
    output logic                          mt_wr_en,
    output logic [AREG_IDX_W-1:0]         mt_wr_base,
    output logic [EPC*PREG_W-1:0]         mt_wr_data,
    output logic                          stall_dispatch,
    output logic                          recover_busy,
    output logic                          recover_done,
    output logic                          proto_err
);

    localparam int NGRP  = NUM_AREGS / EPC;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    rec_state_t                  state;
    rec_state_t                  state_nxt;
    logic [GRP_W-1:0]            grp_cnt;
    logic [GRP_W-1:0]            grp_nxt;
    logic                        capture;
    logic [PREG_W-1:0]           snapshot [NUM_AREGS];
    logic [NUM_AREGS*PREG_W-1:0] snap_flat;
    logic [EPC*PREG_W-1:0]       grp_data;
    logic                        in_copy;

    assign in_copy = (state == ST_COPY);

    // FSM state and group counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            grp_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grp_cnt <= grp_nxt;
        end
    end

    // Snapshot is taken only on a recover request; retirements during COPY never touch it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                snapshot[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                snapshot[i] <= at_lane(at_copy, i);
            end
        end
    end

    // Sticky flag: a retirement during COPY means the snapshot may be stale.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (in_copy && retire_en_any) begin
            proto_err <= 1'b1;
        end
    end

    // Flatten the snapshot array for the group mux.
    always_comb begin
        snap_flat = '0;
        for (int i = 0; i < NUM_AREGS; i++) begin
            snap_flat[i*PREG_W +: PREG_W] = snapshot[i];
        end
    end

    archtable_grp_mux #(
        .EPC   (EPC),
        .NGRP  (NGRP),
        .GRP_W (GRP_W)
    ) u_grp_mux (
        .snap_flat (snap_flat),
        .grp_sel   (grp_cnt),
        .grp_data  (grp_data)
    );

    // Next-state and output decode; a recover request in COPY restarts and beats the final-group exit.
    always_comb begin
        state_nxt      = state;
        grp_nxt        = grp_cnt;
        capture        = 1'b0;
        recover_done   = 1'b0;
        mt_wr_en       = 1'b0;
        mt_wr_base     = '0;
        mt_wr_data     = '0;
        recover_busy   = in_copy;
        stall_dispatch = ~reset & (rob_recover | in_copy);

        case (state)
            ST_IDLE: begin
                if (rob_recover) begin
                    capture   = 1'b1;
                    grp_nxt   = '0;
                    state_nxt = ST_COPY;
                end
            end
            ST_COPY: begin
                mt_wr_en   = 1'b1;
                mt_wr_base = AREG_IDX_W'(int'(grp_cnt) * EPC);
                mt_wr_data = grp_data;
                if (rob_recover) begin
                    capture = 1'b1;
                    grp_nxt = '0;
                end else if (grp_cnt == GRP_W'(NGRP - 1)) begin
                    recover_done = 1'b1;
                    grp_nxt      = '0;
                    state_nxt    = ST_IDLE;
                end else begin
                    grp_nxt = grp_cnt + GRP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grp_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_archtable_recover_ctrl.sv
// tb/tb_archtable_recover_ctrl.sv - self-checking bench for archtable_recover_ctrl (EPC=4 and EPC=1)
module tb_archtable_recover_ctrl;

    logic         clock;
    logic         reset;
    logic         rob_recover;
    logic         retire_en_any;
    logic [191:0] at_copy;

    logic         mt_wr_en0, mt_wr_en1;
    logic [4:0]   mt_wr_base0, mt_wr_base1;
    logic [23:0]  mt_wr_data0;
    logic [5:0]   mt_wr_data1;
    logic         stall0, stall1, busy0, busy1, done0, done1, perr0, perr1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: per DUT, k = group being written this cycle (-1 = not copying).
    int m_k    [2];
    int m_snap [2][32];
    bit m_perr [2];

    archtable_recover_ctrl #(.EPC(4)) dut (
        .clock(clock), .reset(reset), .rob_recover(rob_recover), .retire_en_any(retire_en_any),
        .at_copy(at_copy), .mt_wr_en(mt_wr_en0), .mt_wr_base(mt_wr_base0), .mt_wr_data(mt_wr_data0),
        .stall_dispatch(stall0), .recover_busy(busy0), .recover_done(done0), .proto_err(perr0)
    );

    archtable_recover_ctrl #(.EPC(1)) dut1 (
        .clock(clock), .reset(reset), .rob_recover(rob_recover), .retire_en_any(retire_en_any),
        .at_copy(at_copy), .mt_wr_en(mt_wr_en1), .mt_wr_base(mt_wr_base1), .mt_wr_data(mt_wr_data1),
        .stall_dispatch(stall1), .recover_busy(busy1), .recover_done(done1), .proto_err(perr1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_copy(input int off, input bit all_ones);
        for (int i = 0; i < 32; i++) begin
            at_copy[i*6 +: 6] = all_ones ? 6'h3F : 6'(i + off);
        end
    endtask

    // Reference behaviour: snapshot on recover, then one group per cycle, restart on any new recover.
    always @(posedge clock or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            int ngrp;
            ngrp = (d == 0) ? 8 : 32;
            if (reset) begin
                m_k[d]    = -1;
                m_perr[d] = 1'b0;
                for (int i = 0; i < 32; i++) m_snap[d][i] = 0;
            end else begin
                if (m_k[d] >= 0 && retire_en_any) m_perr[d] = 1'b1;
                if (rob_recover) begin
                    for (int i = 0; i < 32; i++) m_snap[d][i] = int'(at_copy[i*6 +: 6]);
                    m_k[d] = 0;
                end else if (m_k[d] >= 0) begin
                    m_k[d] = (m_k[d] == ngrp - 1) ? -1 : m_k[d] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clock) begin
        if (cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                int          epc;
                bit          act;
                logic [63:0] e_base, e_data, a_data, a_base;
                logic        a_en, a_stall, a_busy, a_done, a_perr;
                epc    = (d == 0) ? 4 : 1;
                act    = (m_k[d] >= 0);
                e_base = act ? 64'(m_k[d] * epc) : 64'd0;
                e_data = 64'd0;
                if (act) begin
                    for (int j = 0; j < epc; j++) e_data[j*6 +: 6] = 6'(m_snap[d][m_k[d]*epc + j]);
                end
                a_en    = (d == 0) ? mt_wr_en0 : mt_wr_en1;
                a_base  = (d == 0) ? 64'(mt_wr_base0) : 64'(mt_wr_base1);
                a_data  = (d == 0) ? 64'(mt_wr_data0) : 64'(mt_wr_data1);
                a_stall = (d == 0) ? stall0 : stall1;
                a_busy  = (d == 0) ? busy0 : busy1;
                a_done  = (d == 0) ? done0 : done1;
                a_perr  = (d == 0) ? perr0 : perr1;
                chk($sformatf("m%0d_wr_en", d), 64'(a_en), 64'(act));
                chk($sformatf("m%0d_wr_base", d), a_base, e_base);
                chk($sformatf("m%0d_wr_data", d), a_data, e_data);
                chk($sformatf("m%0d_stall", d), 64'(a_stall), 64'(!reset && (rob_recover || act)));
                chk($sformatf("m%0d_busy", d), 64'(a_busy), 64'(act));
                chk($sformatf("m%0d_done", d), 64'(a_done),
                    64'(act && m_k[d] == ((d == 0) ? 7 : 31) && !rob_recover));
                chk($sformatf("m%0d_perr", d), 64'(a_perr), 64'(m_perr[d]));
            end
        end
    end

    initial begin
        int wcount, done1_cyc, done0_cyc;
        for (int d = 0; d < 2; d++) begin
            m_k[d]    = -1;
            m_perr[d] = 1'b0;
            for (int i = 0; i < 32; i++) m_snap[d][i] = 0;
        end
        reset         = 1'b1;
        rob_recover   = 1'b0;
        retire_en_any = 1'b0;
        set_copy(32, 1'b0);

        // Reset held: outputs quiet.
        goto(2);
        @(negedge clock);
        chk("rst_wr_en", 64'(mt_wr_en0), 64'd0);
        chk("rst_stall", 64'(stall0), 64'd0);
        chk("rst_perr", 64'(perr0), 64'd0);
        goto(4);
        reset = 1'b0;

        // Basic recover at 10, snapshot hold, protocol error at 13.
        goto(10);
        rob_recover = 1'b1;
        @(negedge clock);
        chk("stall_at_10", 64'(stall0), 64'd1);
        goto(11);
        rob_recover = 1'b0;
        @(negedge clock);
        chk("c11_base", 64'(mt_wr_base0), 64'd0);
        chk("c11_data", 64'(mt_wr_data0), 64'({6'd35, 6'd34, 6'd33, 6'd32}));
        goto(12);
        set_copy(0, 1'b1);
        goto(13);
        retire_en_any = 1'b1;
        @(negedge clock);
        chk("perr_at_13", 64'(perr0), 64'd0);
        goto(14);
        retire_en_any = 1'b0;
        @(negedge clock);
        chk("perr_at_14", 64'(perr0), 64'd1);
        goto(17);
        @(negedge clock);
        chk("done_at_17", 64'(done0), 64'd0);
        goto(18);
        @(negedge clock);
        chk("c18_base", 64'(mt_wr_base0), 64'd28);
        chk("c18_data", 64'(mt_wr_data0), 64'({6'd63, 6'd62, 6'd61, 6'd60}));
        chk("c18_done", 64'(done0), 64'd1);
        goto(19);
        @(negedge clock);
        chk("c19_stall", 64'(stall0), 64'd0);
        chk("c19_wr_en", 64'(mt_wr_en0), 64'd0);
        chk("c19_perr_sticky", 64'(perr0), 64'd1);

        // Asynchronous reset mid-cycle clears proto_err at once.
        goto(20);
        #2 reset = 1'b1;
        #1;
        chk("async_perr_clr", 64'(perr0), 64'd0);
        chk("async_perr1_clr", 64'(perr1), 64'd0);
        goto(23);
        reset = 1'b0;

        // Restart: recover at 30, second recover at 34 with at_copy[i]=i.
        goto(25);
        set_copy(32, 1'b0);
        goto(30);
        rob_recover = 1'b1;
        goto(31);
        rob_recover = 1'b0;
        goto(34);
        set_copy(0, 1'b0);
        rob_recover = 1'b1;
        @(negedge clock);
        chk("restart_no_done", 64'(done0), 64'd0);
        goto(35);
        rob_recover = 1'b0;
        @(negedge clock);
        chk("c35_base", 64'(mt_wr_base0), 64'd0);
        chk("c35_data", 64'(mt_wr_data0), 64'({6'd3, 6'd2, 6'd1, 6'd0}));
        goto(38);
        @(negedge clock);
        chk("c38_no_done", 64'(done0), 64'd0);
        goto(42);
        @(negedge clock);
        chk("c42_base", 64'(mt_wr_base0), 64'd28);
        chk("c42_data", 64'(mt_wr_data0), 64'({6'd31, 6'd30, 6'd29, 6'd28}));
        chk("c42_done", 64'(done0), 64'd1);
        goto(43);
        @(negedge clock);
        chk("c43_wr_en", 64'(mt_wr_en0), 64'd0);

        // Reset mid-COPY: outputs drop immediately, no writes after release.
        goto(70);
        set_copy(32, 1'b0);
        rob_recover = 1'b1;
        goto(71);
        rob_recover = 1'b0;
        goto(75);
        #2 reset = 1'b1;
        #1;
        chk("midcopy_wr_en", 64'(mt_wr_en0), 64'd0);
        chk("midcopy_stall", 64'(stall0), 64'd0);
        chk("midcopy_busy", 64'(busy0), 64'd0);
        chk("midcopy_wr_en1", 64'(mt_wr_en1), 64'd0);
        goto(78);
        reset = 1'b0;
        goto(85);
        @(negedge clock);
        chk("post_rst_no_wr", 64'(mt_wr_en0 | mt_wr_en1), 64'd0);

        // EPC=1: 32 write cycles, done at N+32 (EPC=4 done at N+8).
        goto(90);
        rob_recover = 1'b1;
        goto(91);
        rob_recover = 1'b0;
        wcount    = 0;
        done1_cyc = -1;
        done0_cyc = -1;
        for (int c = 91; c <= 126; c++) begin
            goto(c);
            @(negedge clock);
            if (mt_wr_en1) wcount++;
            if (done1) done1_cyc = c;
            if (done0) done0_cyc = c;
        end
        chk("epc1_write_count", 64'(wcount), 64'd32);
        chk("epc1_done_cycle", 64'(done1_cyc), 64'd122);
        chk("epc4_done_cycle", 64'(done0_cyc), 64'd98);

        goto(130);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
